full_adder_1bit_slice: RTL and testbench

- 1-bit full adder slice: sum = a XOR b XOR cin, cout = majority(a, b, cin).
- Provides a combinational result path and a registered, valid/ready-handshaked result path.
- Optional bit-serial mode keeps the carry in a register across beats, LSB first.
- Building block for ripple-carry and bit-serial adders in the arithmetic library.

---
 rtl/full_adder_1bit_slice_pkg.sv | 34 +++
 rtl/full_adder_1bit_slice_if.sv | 31 +++
 rtl/full_adder_1bit_comb.sv | 18 +
 rtl/full_adder_1bit_slice.sv | 111 +++++++++++
 tb/tb_full_adder_1bit_slice.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/full_adder_1bit_slice_pkg.sv
// Shared arithmetic helpers, parameter defaults and state type for the 1-bit
// full-adder slice.
package full_adder_1bit_slice_pkg;

  localparam bit DEF_REG_OUT   = 1'b1;
  localparam bit DEF_SERIAL_EN = 1'b0;

  // Output-stage occupancy; also exported on the debug port.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } slice_state_e;

  typedef struct packed {
    logic cout;
    logic sum;
  } fa_res_t;

  function automatic logic fa_sum(input logic a, input logic b, input logic c);
    return a ^ b ^ c;
  endfunction

  function automatic logic fa_maj(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  function automatic fa_res_t fa_add(input logic a, input logic b, input logic c);
    fa_res_t r;
    r.sum  = fa_sum(a, b, c);
    r.cout = fa_maj(a, b, c);
    return r;
  endfunction

endpackage

// File: rtl/full_adder_1bit_slice_if.sv
// Operand/result bundle of the full-adder slice, with master (driver) and
// slave (slice) views.
interface full_adder_1bit_slice_if;

  // Handshake: a beat transfers on a cycle where in_valid && in_ready; a result
  // drains on a cycle where out_valid && out_ready. Neither valid may depend on
  // its own ready.
  logic in_valid;
  logic in_ready;
  logic a;
  logic b;
  logic cin;
  logic first;
  logic sum_comb;
  logic cout_comb;
  logic sum;
  logic cout;
  logic out_valid;
  logic out_ready;

  modport master (
    output in_valid, a, b, cin, first, out_ready,
    input  in_ready, sum_comb, cout_comb, sum, cout, out_valid
  );

  modport slave (
    input  in_valid, a, b, cin, first, out_ready,
    output in_ready, sum_comb, cout_comb, sum, cout, out_valid
  );

endinterface

// File: rtl/full_adder_1bit_comb.sv
// Pure combinational 1-bit full adder.
module full_adder_1bit_comb
  import full_adder_1bit_slice_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic sum,
  output logic cout
);

  fa_res_t res;

  assign res  = fa_add(a, b, ci);
  assign sum  = res.sum;
  assign cout = res.cout;

endmodule

// File: rtl/full_adder_1bit_slice.sv
// 1-bit full-adder slice: combinational result path, optional registered
// valid/ready result stage, and optional bit-serial carry register.
module full_adder_1bit_slice
  import full_adder_1bit_slice_pkg::*;
#(
  parameter bit REG_OUT   = DEF_REG_OUT,
  parameter bit SERIAL_EN = DEF_SERIAL_EN
) (
  input  logic                    clk,
  input  logic                    rst_n,
  full_adder_1bit_slice_if.slave  bus,
  output slice_state_e            state_o
);

  logic         ci;
  logic         sum_c;
  logic         cout_c;
  logic         accept;
  logic         carry_q;
  logic         carry_d;
  logic         in_ready_w;
  logic         out_valid_w;
  logic         sum_w;
  logic         cout_w;
  slice_state_e state_w;

  // The stored carry only replaces cin on non-LSB beats of a serial word.
  assign ci = (!SERIAL_EN || bus.first) ? bus.cin : carry_q;

  full_adder_1bit_comb u_comb (
    .a    (bus.a),
    .b    (bus.b),
    .ci   (ci),
    .sum  (sum_c),
    .cout (cout_c)
  );

  assign accept = bus.in_valid && in_ready_w;

  always_comb begin
    carry_d = carry_q;
    if (SERIAL_EN && accept) begin
      carry_d = cout_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_q <= 1'b0;
    end else begin
      carry_q <= carry_d;
    end
  end

  if (REG_OUT) begin : g_reg
    slice_state_e state_q;
    slice_state_e state_d;
    logic         sum_q;
    logic         sum_d;
    logic         cout_q;
    logic         cout_d;

    // A new beat overwrites a draining result, giving one beat per cycle.
    always_comb begin
      state_d = state_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      if (accept) begin
        state_d = ST_FULL;
        sum_d   = sum_c;
        cout_d  = cout_c;
      end else if (state_q == ST_FULL && bus.out_ready) begin
        state_d = ST_EMPTY;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= ST_EMPTY;
        sum_q   <= 1'b0;
        cout_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        sum_q   <= sum_d;
        cout_q  <= cout_d;
      end
    end

    assign out_valid_w = (state_q == ST_FULL);
    assign in_ready_w  = !out_valid_w || bus.out_ready;
    assign sum_w       = sum_q;
    assign cout_w      = cout_q;
    assign state_w     = state_q;
  end else begin : g_pass
    // Pass-through: the result port is just a view of the combinational path.
    assign out_valid_w = bus.in_valid;
    assign in_ready_w  = bus.out_ready || !rst_n;
    assign sum_w       = sum_c;
    assign cout_w      = cout_c;
    assign state_w     = bus.in_valid ? ST_FULL : ST_EMPTY;
  end

  assign bus.sum_comb  = sum_c;
  assign bus.cout_comb = cout_c;
  assign bus.sum       = sum_w;
  assign bus.cout      = cout_w;
  assign bus.out_valid = out_valid_w;
  assign bus.in_ready  = in_ready_w;
  assign state_o       = state_w;

endmodule

// File: tb/tb_full_adder_1bit_slice.sv
// Bench for the full-adder slice: three configurations (registered, serial,
// pass-through) checked against an arithmetic model plus directed literals.
module tb_full_adder_1bit_slice;
  import full_adder_1bit_slice_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  full_adder_1bit_slice_if if_r ();
  full_adder_1bit_slice_if if_s ();
  full_adder_1bit_slice_if if_n ();

  slice_state_e st_r;
  slice_state_e st_s;
  slice_state_e st_n;

  full_adder_1bit_slice #(.REG_OUT(1'b1), .SERIAL_EN(1'b0)) u_reg (
    .clk(clk), .rst_n(rst_n), .bus(if_r), .state_o(st_r));
  full_adder_1bit_slice #(.REG_OUT(1'b1), .SERIAL_EN(1'b1)) u_ser (
    .clk(clk), .rst_n(rst_n), .bus(if_s), .state_o(st_s));
  full_adder_1bit_slice #(.REG_OUT(1'b0), .SERIAL_EN(1'b0)) u_pass (
    .clk(clk), .rst_n(rst_n), .bus(if_n), .state_o(st_n));

  int checks = 0;
  int errors = 0;

  function automatic logic [1:0] add3(input logic x, input logic y, input logic z);
    int t;
    t = int'(x) + int'(y) + int'(z);
    return t[1:0];
  endfunction

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard model ----------------
  // Each queue holds the result the output stage should be presenting.
  logic [1:0] exp_r_q[$];
  logic [1:0] exp_s_q[$];
  logic       carry_m;
  logic       ci_m;

  assign ci_m = if_s.first ? if_s.cin : carry_m;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_r_q.delete();
    end else if (if_r.in_valid && (exp_r_q.size() == 0 || if_r.out_ready)) begin
      exp_r_q.delete();
      exp_r_q.push_back(add3(if_r.a, if_r.b, if_r.cin));
    end else if (if_r.out_ready) begin
      exp_r_q.delete();
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_s_q.delete();
      carry_m <= 1'b0;
    end else if (if_s.in_valid && (exp_s_q.size() == 0 || if_s.out_ready)) begin
      exp_s_q.delete();
      exp_s_q.push_back(add3(if_s.a, if_s.b, ci_m));
      carry_m <= (int'(if_s.a) + int'(if_s.b) + int'(ci_m)) >= 2;
    end else if (if_s.out_ready) begin
      exp_s_q.delete();
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      chk("r_comb", 4'({if_r.cout_comb, if_r.sum_comb}), 4'(add3(if_r.a, if_r.b, if_r.cin)));
      chk("r_in_ready", 4'(if_r.in_ready), 4'(exp_r_q.size() == 0 || if_r.out_ready));
      chk("r_out_valid", 4'(if_r.out_valid), 4'(exp_r_q.size() != 0));
      chk("r_state", 4'(st_r), 4'(exp_r_q.size() != 0 ? ST_FULL : ST_EMPTY));
      if (exp_r_q.size() != 0)
        chk("r_result", 4'({if_r.cout, if_r.sum}), 4'(exp_r_q[0]));

      chk("s_comb", 4'({if_s.cout_comb, if_s.sum_comb}), 4'(add3(if_s.a, if_s.b, ci_m)));
      chk("s_in_ready", 4'(if_s.in_ready), 4'(exp_s_q.size() == 0 || if_s.out_ready));
      chk("s_out_valid", 4'(if_s.out_valid), 4'(exp_s_q.size() != 0));
      if (exp_s_q.size() != 0)
        chk("s_result", 4'({if_s.cout, if_s.sum}), 4'(exp_s_q[0]));

      chk("n_comb", 4'({if_n.cout_comb, if_n.sum_comb}), 4'(add3(if_n.a, if_n.b, if_n.cin)));
      chk("n_port", 4'({if_n.out_valid, if_n.cout, if_n.sum}),
          4'({if_n.in_valid, add3(if_n.a, if_n.b, if_n.cin)}));
      chk("n_in_ready", 4'(if_n.in_ready), 4'(if_n.out_ready));
    end
  end

  // ---------------- driver ----------------
  logic [7:0] sum_tab;
  logic [7:0] cout_tab;
  logic [2:0] v;
  logic [3:0] va;
  logic [3:0] vb;
  logic [3:0] vc;
  logic [3:0] vs;
  logic [3:0] vo;

  initial begin
    if_r.in_valid = 1'b0; if_r.a = 1'b0; if_r.b = 1'b0; if_r.cin = 1'b0;
    if_r.first = 1'b0; if_r.out_ready = 1'b0;
    if_s.in_valid = 1'b0; if_s.a = 1'b0; if_s.b = 1'b0; if_s.cin = 1'b0;
    if_s.first = 1'b0; if_s.out_ready = 1'b1;
    if_n.in_valid = 1'b0; if_n.a = 1'b0; if_n.b = 1'b0; if_n.cin = 1'b0;
    if_n.first = 1'b0; if_n.out_ready = 1'b0;

    // Reset state, observed while rst_n is still low.
    #2;
    chk("rst_r_out", 4'({if_r.out_valid, if_r.cout, if_r.sum}), 4'b0000);
    chk("rst_r_in_ready", 4'(if_r.in_ready), 4'b0001);
    chk("rst_s_out", 4'({if_s.out_valid, if_s.cout, if_s.sum}), 4'b0000);
    chk("rst_n_in_ready", 4'(if_n.in_ready), 4'b0001);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    if_r.out_ready = 1'b1;
    if_n.out_ready = 1'b1;

    // Exhaustive truth table, index = {a,b,cin}.
    sum_tab  = 8'b1001_0110;
    cout_tab = 8'b1110_1000;
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      if_r.a = v[2]; if_r.b = v[1]; if_r.cin = v[0]; if_r.in_valid = 1'b1;
      #1;
      chk("tt_comb", 4'({if_r.cout_comb, if_r.sum_comb}), 4'({cout_tab[i], sum_tab[i]}));
      tick;
      chk("tt_reg", 4'({if_r.out_valid, if_r.cout, if_r.sum}), 4'({1'b1, cout_tab[i], sum_tab[i]}));
    end
    if_r.in_valid = 1'b0;
    tick;
    chk("tt_drain", 4'(if_r.out_valid), 4'b0000);

    // Backpressure: accept 1+0+0, then stall three cycles.
    if_r.a = 1'b1; if_r.b = 1'b0; if_r.cin = 1'b0; if_r.in_valid = 1'b1;
    if_r.out_ready = 1'b0;
    #1;
    chk("bp_accept_ready", 4'(if_r.in_ready), 4'b0001);
    tick;
    if_r.in_valid = 1'b0; if_r.a = 1'b0; if_r.b = 1'b1; if_r.cin = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk("bp_in_ready", 4'(if_r.in_ready), 4'b0000);
      chk("bp_hold", 4'({if_r.out_valid, if_r.cout, if_r.sum}), 4'b0101);
      tick;
    end
    if_r.out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 4'(if_r.in_ready), 4'b0001);
    tick;
    chk("bp_drained", 4'({if_r.out_valid, if_r.sum}), 4'b0001);

    // Streaming: beats (1,1,0) (0,1,0) (1,1,1) (0,0,1), bit i = beat i.
    va = 4'b0101; vb = 4'b0111; vc = 4'b1100;
    vs = 4'b1110; vo = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      if_r.a = va[i]; if_r.b = vb[i]; if_r.cin = vc[i]; if_r.in_valid = 1'b1;
      #1;
      chk("st_in_ready", 4'(if_r.in_ready), 4'b0001);
      if (i > 0)
        chk("st_result", 4'({if_r.out_valid, if_r.cout, if_r.sum}), 4'({1'b1, vo[i-1], vs[i-1]}));
      tick;
    end
    chk("st_last", 4'({if_r.out_valid, if_r.cout, if_r.sum}), 4'({1'b1, vo[3], vs[3]}));
    if_r.in_valid = 1'b0;
    tick;

    // Serial 9 + 7, LSB first: every beat gives sum 0 carry 1.
    va = 4'b1001; vb = 4'b0111;
    for (int i = 0; i < 4; i++) begin
      if_s.a = va[i]; if_s.b = vb[i]; if_s.cin = 1'b0;
      if_s.first = (i == 0); if_s.in_valid = 1'b1;
      tick;
      chk("ser_beat", 4'({if_s.out_valid, if_s.cout, if_s.sum}), 4'b0110);
    end
    if_s.in_valid = 1'b0; if_s.first = 1'b0;
    tick;

    // Asynchronous reset in the middle of a serial word.
    if_s.a = 1'b1; if_s.b = 1'b1; if_s.cin = 1'b0; if_s.first = 1'b1; if_s.in_valid = 1'b1;
    tick;
    if_s.a = 1'b1; if_s.b = 1'b0; if_s.first = 1'b0;
    tick;
    if_s.in_valid = 1'b0;
    chk("mid_word", 4'({if_s.out_valid, if_s.cout, if_s.sum}), 4'b0110);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_s", 4'({if_s.out_valid, if_s.cout, if_s.sum}), 4'b0000);
    chk("async_rst_s_ready", 4'(if_s.in_ready), 4'b0001);
    #3;
    rst_n = 1'b1;
    if_s.a = 1'b0; if_s.b = 1'b0; if_s.cin = 1'b1; if_s.first = 1'b0; if_s.in_valid = 1'b1;
    #1;
    chk("post_rst_comb", 4'({if_s.cout_comb, if_s.sum_comb}), 4'b0000);
    tick;
    chk("post_rst_reg", 4'({if_s.out_valid, if_s.cout, if_s.sum}), 4'b0100);
    if_s.in_valid = 1'b0;
    tick;

    // Pass-through configuration: same-cycle result.
    if_n.a = 1'b0; if_n.b = 1'b1; if_n.cin = 1'b1; if_n.in_valid = 1'b1;
    #1;
    chk("pass_out", 4'({if_n.out_valid, if_n.cout, if_n.sum}), 4'b0110);
    chk("pass_ready", 4'(if_n.in_ready), 4'b0001);
    if_n.in_valid = 1'b0; if_n.out_ready = 1'b0;
    #1;
    chk("pass_idle", 4'({if_n.out_valid, if_n.in_ready}), 4'b0000);
    if_n.out_ready = 1'b1;
    tick;
    tick;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
